riscv_core_wb_arb: RTL

Writeback arbiter for the RV64IMAC core. It merges the in-order pipeline writeback and a long-latency unit (divider/AMO) writeback onto the single register-file write port (we3/a3/wd3). Long-latency results are buffered in a small FIFO and drained into free pipeline slots. A starvation counter forces a one-cycle pipeline bubble when needed, and a hazard check flags source registers that still have queued writes.

---
 rtl/riscv_core_wb_arb.sv | 122 ++++++++++++
 1 files changed

// File: rtl/riscv_core_wb_arb.sv
// rtl/riscv_core_wb_arb.sv - writeback arbiter merging pipeline and long-latency results onto the RF write port
module riscv_core_wb_arb #(
  parameter int XLEN       = 64,
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic            i_wb_clk,
  input  logic            i_wb_rst_n,
  input  logic            i_wb_pipe_we,
  input  logic [4:0]      i_wb_pipe_rd,
  input  logic [XLEN-1:0] i_wb_pipe_data,
  input  logic            i_wb_lu_valid,
  input  logic [4:0]      i_wb_lu_rd,
  input  logic [XLEN-1:0] i_wb_lu_data,
  output logic            o_wb_lu_ready,
  input  logic [4:0]      i_wb_chk_a1,
  input  logic [4:0]      i_wb_chk_a2,
  output logic            o_wb_hazard,
  output logic            o_wb_stall,
  output logic            o_wb_we3,
  output logic [4:0]      o_wb_a3,
  output logic [XLEN-1:0] o_wb_wd3
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(DEPTH);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  logic [4:0]      q_rd   [DEPTH];
  logic [XLEN-1:0] q_data [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [SW-1:0]   starve;
  logic [DEPTH-1:0] q_valid;

  logic empty;
  logic pipe_eff;
  logic push;
  logic pop;

  // Offset of a slot from the head, wrapping in pointer width.
  function automatic logic [AW-1:0] slot_off(input logic [AW-1:0] slot, input logic [AW-1:0] head);
    return slot - head;
  endfunction

  assign empty         = (count == '0);
  assign o_wb_lu_ready = (count != FULL_CNT);
  assign pipe_eff      = i_wb_pipe_we && (i_wb_pipe_rd != 5'd0) && !o_wb_stall;
  assign push          = i_wb_lu_valid && o_wb_lu_ready && (i_wb_lu_rd != 5'd0);
  assign pop           = !pipe_eff && !empty;

  always_comb begin
    q_valid     = '0;
    o_wb_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      q_valid[i] = (CW'(slot_off(AW'(i), rd_ptr)) < count);
      if (q_valid[i] &&
          (((i_wb_chk_a1 != 5'd0) && (i_wb_chk_a1 == q_rd[i])) ||
           ((i_wb_chk_a2 != 5'd0) && (i_wb_chk_a2 == q_rd[i])))) begin
        o_wb_hazard = 1'b1;
      end
    end
  end

  always_ff @(posedge i_wb_clk) begin
    if (push) begin
      q_rd[wr_ptr]   <= i_wb_lu_rd;
      q_data[wr_ptr] <= i_wb_lu_data;
    end
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // The stall cycle itself always drains the head, so the stall never repeats back-to-back.
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      starve     <= '0;
      o_wb_stall <= 1'b0;
      o_wb_we3   <= 1'b0;
      o_wb_a3    <= '0;
      o_wb_wd3   <= '0;
    end else begin
      o_wb_stall <= !o_wb_stall && (starve == STARVE_TOP) && !empty;

      if (empty || pop) begin
        starve <= '0;
      end else if (pipe_eff && (starve != STARVE_TOP)) begin
        starve <= starve + SW'(1);
      end

      if (pipe_eff) begin
        o_wb_we3 <= 1'b1;
        o_wb_a3  <= i_wb_pipe_rd;
        o_wb_wd3 <= i_wb_pipe_data;
      end else if (!empty) begin
        o_wb_we3 <= 1'b1;
        o_wb_a3  <= q_rd[rd_ptr];
        o_wb_wd3 <= q_data[rd_ptr];
      end else begin
        o_wb_we3 <= 1'b0;
      end
    end
  end

endmodule
